raggedstone_spinn_aer_if_mode_sel: RTL
======================================

# raggedstone_spinn_aer_if_mode_sel

User-interface mode selector that sits directly downstream of the pushbutton debouncer in the Raggedstone SpiNNaker–AER interface. It consumes the debounced button level and detects press/release events. A short press steps a mode register cyclically through `NUM_MODES` values; a long press returns it to `DEFAULT_MODE`. After every mode change it blinks an LED (mode+1) times as operator feedback.

## Interface
Parameters:
- `NUM_MODES`, 4: number of selectable modes, 2..2^`MODE_BITS`.
- `MODE_BITS`, 2: width of `mode`.
- `DEFAULT_MODE`, 0: reset and long-press mode value, < `NUM_MODES`.
- `PB_ACTIVE`, 1'b0: `pb_debounced` level meaning "pressed". The debouncer resets to 1, meaning released.
- `LONG_CONST`, 24'hffffff: hold cycles for a long press, ≥2. Reduce for simulation.
- `BLINK_CONST`, 22'h3fffff: LED on-time and off-time per blink, in cycles, ≥1. Reduce for simulation.

Ports:
- `rst` input 1: reset, asynchronous, active-high.
- `clk` input 1: single clock. All logic is in this domain.
- `pb_debounced` input 1: debounced button level from the debouncer, synchronous to `clk`.
- `mode` output `MODE_BITS`: current mode. Registered.
- `mode_chg` output 1: one-cycle pulse after each `mode` update. Registered.
- `led` output 1: feedback LED, active-high. Registered.

## Operation
Input sampling:
- `pb_q` is a 1-cycle registered copy of `pb_debounced`. It resets to `PB_ACTIVE`.
- Consequence: a button held through reset is not a press. The operator must release and press again.
- Press edge: `pb_debounced`==`PB_ACTIVE` && `pb_q`!=`PB_ACTIVE`.

Button FSM, states IDLE, PRESSED, HELD:
- IDLE → PRESSED on a press edge. `hold_cnt` is cleared to 0.
- PRESSED, still pressed: `hold_cnt` increments each cycle.
- PRESSED, `hold_cnt`==`LONG_CONST`-1 and still pressed: long press. `mode`←`DEFAULT_MODE`, `mode_chg` fires, FSM → HELD.
- PRESSED, released: short press. `mode`←(`mode`==`NUM_MODES`-1) ? 0 : `mode`+1, `mode_chg` fires, FSM → IDLE.
- HELD, released → IDLE with no mode action. HELD, pressed → stay in HELD.
- A long press fires `mode_chg` even if `mode` already equals `DEFAULT_MODE`.
- Width rule: `hold_cnt` is 24 bits and saturates. It never wraps into a second long press.

Blink FSM, states B_IDLE, B_ON, B_OFF:
- Any `mode_chg`: `blinks`←new `mode`+1 (`MODE_BITS`+1 wide) and `blink_cnt`←`BLINK_CONST`-1. FSM → B_ON, `led`=1.
- B_ON: `blink_cnt` counts down to 0, then `blink_cnt` reloads, FSM → B_OFF, `led`=0, and `blinks` decrements.
- B_OFF: `blink_cnt` counts down to 0, then FSM → B_ON if `blinks`≠0, otherwise → B_IDLE.
- A new `mode_chg` during a blink sequence aborts it and restarts for the new mode. Restart takes priority over the countdown.
- B_IDLE: `led`=0.

Reset values: `mode`=`DEFAULT_MODE`, `mode_chg`=0, `led`=0, both FSMs idle, counters 0.

Reset mid-operation clears all state immediately. A press in progress is discarded with no mode change.

## Timing
- Short press: `pb_debounced` returns to released before edge k. At edge k, `mode` updates and `mode_chg` rises; `mode_chg` falls at edge k+1.
- Long press: press edge at edge p. Long press fires at edge p+`LONG_CONST`.
- Blink: `led` rises at the same edge as `mode_chg`. Each blink is `BLINK_CONST` cycles high then `BLINK_CONST` cycles low.
- Total blink sequence: 2·(`mode`+1)·`BLINK_CONST` cycles.
- Minimum press length is 1 cycle. There is no internal debounce: input is trusted.

## Configuration
- `RAGGEDSTONE_SPINN_AER_IF_MODE_SEL_LONG_PRESS_EN`:
  - Defined: long-press behaviour as above.
  - Undefined: `hold_cnt` and the HELD state are removed. PRESSED exits only on release, so every press of any duration is a short press. `LONG_CONST` is ignored.

## Test plan
Bench parameters: `NUM_MODES`=3, `MODE_BITS`=2, `DEFAULT_MODE`=0, `PB_ACTIVE`=0, `LONG_CONST`=16, `BLINK_CONST`=4.
- Reset, then idle 50 cycles → `mode`=0, `mode_chg`=0, `led`=0 throughout.
- 3 presses of 5 cycles each, 40 cycles apart → `mode` steps 1, 2, then wraps to 0. Each step gives one 1-cycle `mode_chg` on the release edge.
- Press held 30 cycles from `mode`=2 → at press+16: `mode`=0, one `mode_chg`. Release gives no further change. With the macro undefined: `mode` wraps to 0 at release.
- After a change to `mode`=2 → `led` shows 3 pulses, each 4 high / 4 low, then stays 0.
- Second short press 6 cycles into a blink sequence → sequence restarts at `mode_chg` with the new count.
- `pb_debounced`=0 across reset release, then released, then pressed for 3 cycles → no change at reset exit; a single increment after the later press.

Source files
------------

// File: rtl/raggedstone_spinn_aer_if_mode_sel_if.sv
// Button/mode/LED bundle between the UI mode selector and its environment.
interface raggedstone_spinn_aer_if_mode_sel_if #(
    parameter int MODE_BITS = 2
);
    logic                 pb_debounced;
    logic [MODE_BITS-1:0] mode;
    logic                 mode_chg;
    logic                 led;

    modport master (output pb_debounced, input mode, input mode_chg, input led);
    modport slave  (input pb_debounced, output mode, output mode_chg, output led);
endinterface

// File: rtl/raggedstone_spinn_aer_if_mode_sel.sv
// Pushbutton mode selector: short press steps the mode, long press restores the default,
// LED blinks mode+1 times per change. Long press exists only with RAGGEDSTONE_SPINN_AER_IF_MODE_SEL_LONG_PRESS_EN.
module raggedstone_spinn_aer_if_mode_sel #(
    parameter int          NUM_MODES    = 4,
    parameter int          MODE_BITS    = 2,
    parameter int          DEFAULT_MODE = 0,
    parameter logic        PB_ACTIVE    = 1'b0,
    parameter logic [23:0] LONG_CONST   = 24'hffffff,
    parameter logic [21:0] BLINK_CONST  = 22'h3fffff
) (
    input  logic clk,
    input  logic rst,
    raggedstone_spinn_aer_if_mode_sel_if.slave bus
);
    localparam logic [MODE_BITS-1:0] LP_DEF   = MODE_BITS'(DEFAULT_MODE);
    localparam logic [MODE_BITS-1:0] LP_LAST  = MODE_BITS'(NUM_MODES - 1);
    localparam logic [MODE_BITS-1:0] LP_M_ONE = MODE_BITS'(1);
    localparam logic [MODE_BITS:0]   LP_B_ONE = (MODE_BITS+1)'(1);
    localparam logic [21:0]          LP_RLD   = BLINK_CONST - 22'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED
`ifdef RAGGEDSTONE_SPINN_AER_IF_MODE_SEL_LONG_PRESS_EN
        , S_HELD
`endif
    } btn_t;

    typedef enum logic [1:0] {B_IDLE, B_ON, B_OFF} blk_t;

    btn_t                 r_btn, w_btn_nxt;
    blk_t                 r_blk, w_blk_nxt;
    logic                 r_pb_q;
    logic [MODE_BITS-1:0] r_mode, w_mode_nxt;
    logic                 r_mode_chg;
    logic                 r_led, w_led_nxt;
    logic [MODE_BITS:0]   r_blinks, w_blinks_nxt;
    logic [21:0]          r_blink_cnt, w_cnt_nxt;
    logic                 w_pressed, w_press_edge;
    logic                 w_short, w_long, w_mode_upd;

`ifdef RAGGEDSTONE_SPINN_AER_IF_MODE_SEL_LONG_PRESS_EN
    logic [23:0]          r_hold_cnt, w_hold_nxt;
`else
    logic                 w_unused_long;
    assign w_unused_long = ^LONG_CONST;
`endif

    // pb_q resets to "pressed" so a button held through reset never looks like a new press
    assign w_pressed    = (bus.pb_debounced == PB_ACTIVE);
    assign w_press_edge = w_pressed && (r_pb_q != PB_ACTIVE);

    always_comb begin
        w_btn_nxt = r_btn;
        w_short   = 1'b0;
        w_long    = 1'b0;
`ifdef RAGGEDSTONE_SPINN_AER_IF_MODE_SEL_LONG_PRESS_EN
        w_hold_nxt = r_hold_cnt;
`endif
        case (r_btn)
            S_IDLE: begin
                if (w_press_edge) begin
                    w_btn_nxt = S_PRESSED;
`ifdef RAGGEDSTONE_SPINN_AER_IF_MODE_SEL_LONG_PRESS_EN
                    w_hold_nxt = '0;
`endif
                end
            end
            S_PRESSED: begin
                if (!w_pressed) begin
                    w_short   = 1'b1;
                    w_btn_nxt = S_IDLE;
                end
`ifdef RAGGEDSTONE_SPINN_AER_IF_MODE_SEL_LONG_PRESS_EN
                else if (r_hold_cnt == LONG_CONST - 24'd1) begin
                    w_long    = 1'b1;
                    w_btn_nxt = S_HELD;
                end else if (r_hold_cnt != '1) begin
                    w_hold_nxt = r_hold_cnt + 24'd1;
                end
`endif
            end
`ifdef RAGGEDSTONE_SPINN_AER_IF_MODE_SEL_LONG_PRESS_EN
            S_HELD: begin
                if (!w_pressed) w_btn_nxt = S_IDLE;
            end
`endif
            default: w_btn_nxt = S_IDLE;
        endcase
    end

    assign w_mode_upd = w_short | w_long;
    assign w_mode_nxt = w_long ? LP_DEF :
                        (r_mode == LP_LAST) ? '0 : r_mode + LP_M_ONE;

    // a fresh mode change always restarts the blink train, overriding any countdown
    always_comb begin
        w_blk_nxt    = r_blk;
        w_cnt_nxt    = r_blink_cnt;
        w_blinks_nxt = r_blinks;
        if (w_mode_upd) begin
            w_blk_nxt    = B_ON;
            w_cnt_nxt    = LP_RLD;
            w_blinks_nxt = {1'b0, w_mode_nxt} + LP_B_ONE;
        end else begin
            case (r_blk)
                B_ON: begin
                    if (r_blink_cnt == '0) begin
                        w_blk_nxt    = B_OFF;
                        w_cnt_nxt    = LP_RLD;
                        w_blinks_nxt = r_blinks - LP_B_ONE;
                    end else begin
                        w_cnt_nxt = r_blink_cnt - 22'd1;
                    end
                end
                B_OFF: begin
                    if (r_blink_cnt == '0) begin
                        if (r_blinks != '0) begin
                            w_blk_nxt = B_ON;
                            w_cnt_nxt = LP_RLD;
                        end else begin
                            w_blk_nxt = B_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_blink_cnt - 22'd1;
                    end
                end
                default: w_blk_nxt = B_IDLE;
            endcase
        end
    end

    assign w_led_nxt = (w_blk_nxt == B_ON);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pb_q      <= PB_ACTIVE;
            r_btn       <= S_IDLE;
            r_mode      <= LP_DEF;
            r_mode_chg  <= 1'b0;
            r_blk       <= B_IDLE;
            r_blinks    <= '0;
            r_blink_cnt <= '0;
            r_led       <= 1'b0;
`ifdef RAGGEDSTONE_SPINN_AER_IF_MODE_SEL_LONG_PRESS_EN
            r_hold_cnt  <= '0;
`endif
        end else begin
            r_pb_q      <= bus.pb_debounced;
            r_btn       <= w_btn_nxt;
            r_mode_chg  <= w_mode_upd;
            if (w_mode_upd) r_mode <= w_mode_nxt;
            r_blk       <= w_blk_nxt;
            r_blinks    <= w_blinks_nxt;
            r_blink_cnt <= w_cnt_nxt;
            r_led       <= w_led_nxt;
`ifdef RAGGEDSTONE_SPINN_AER_IF_MODE_SEL_LONG_PRESS_EN
            r_hold_cnt  <= w_hold_nxt;
`endif
        end
    end

    assign bus.mode     = r_mode;
    assign bus.mode_chg = r_mode_chg;
    assign bus.led      = r_led;
endmodule
